// File: rtl/systolic_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_drain_if
//  Description : Bundle of signals between the systolic unit, the result
//                drain and the downstream element stream.
//                  res_valid / res_vec / bias : finished vector + bias in
//                  out_valid / out_ready      : element stream handshake
//                  out_data / out_idx / out_last : current element
//                  occupancy / overflow       : buffer status
//                Modport slave  : the drain (consumes vectors, drives stream)
//                Modport master : the environment around the drain
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_result_drain_if #(
    parameter int DATA_W     = 32,
    parameter int OUT_DIM    = 1,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_idx_w = $clog2(OUT_DIM) + 1;
    localparam int c_occ_w = $clog2(FIFO_DEPTH) + 1;

    logic                            res_valid;
    logic [OUT_DIM-1:0][DATA_W-1:0]  res_vec;
    logic [OUT_DIM-1:0][DATA_W-1:0]  bias;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_W-1:0]               out_data;
    logic [c_idx_w-1:0]              out_idx;
    logic                            out_last;
    logic [c_occ_w-1:0]              occupancy;
    logic                            overflow;

    modport master (
        output res_valid, res_vec, bias, out_ready,
        input  out_valid, out_data, out_idx, out_last, occupancy, overflow
    );

    modport slave (
        input  res_valid, res_vec, bias, out_ready,
        output out_valid, out_data, out_idx, out_last, occupancy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_drain
//  Description : Captures each finished result vector of the systolic unit,
//                adds a per-row bias, buffers up to FIFO_DEPTH vectors and
//                streams them one element per beat on a valid/ready port.
//                Optional macro RELU_EN: clamp negative elements to zero on
//                the read side (the FIFO always holds pre-activation sums).
//  Ports       : clk   - clock, all logic on posedge
//                reset - synchronous, active-low (0 = reset)
//                bus   - systolic_result_drain_if.slave (vector in, element
//                        stream out, occupancy and sticky overflow status)
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
    parameter int DATA_W     = 32,
    parameter int OUT_DIM    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    systolic_result_drain_if.slave bus
);
    localparam int c_idx_w = $clog2(OUT_DIM) + 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_occ_w = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(OUT_DIM - 1);
    localparam logic [c_occ_w-1:0] c_full     = c_occ_w'(FIFO_DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_one  = c_occ_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Vector storage; holds biased sums before any activation.
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH][OUT_DIM];

    state_t             r_state;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;
    logic [c_idx_w-1:0] r_idx;
    logic               r_out_valid;
    logic               r_overflow;

    logic               w_last;
    logic               w_fire;
    logic               w_pop;
    logic               w_slot;
    logic               w_push;
    logic               w_drop;
    logic [c_occ_w-1:0] w_occ_next;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_act;

    assign w_last = (r_idx == c_last_idx);
    assign w_fire = r_out_valid && bus.out_ready;
    assign w_pop  = w_fire && w_last;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign w_slot = (r_occ != c_full) || w_pop;
    assign w_push = bus.res_valid && w_slot;
    assign w_drop = bus.res_valid && !w_slot;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + c_occ_one;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - c_occ_one;
        end
    end

    // Storage write: element-wise biased sum, wrapping at DATA_W bits.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            for (int e = 0; e < OUT_DIM; e++) begin
                r_mem[r_wr_ptr][e] <= bus.res_vec[e] + bus.bias[e];
            end
        end
    end

    // Stream control FSM with registered valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_fire) begin
                r_idx <= w_last ? '0 : r_idx + c_idx_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_occ <= w_occ_next;

            case (r_state)
                ST_EMPTY: begin
                    if (w_occ_next != '0) begin
                        r_state     <= ST_STREAM;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    // Next vector follows the last beat directly, no bubble.
                    if (w_occ_next == '0) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Head element select; the head slot cannot be overwritten while it is
    // streaming, so the output holds steady under back-pressure.
    always_comb begin
        w_sum = '0;
        for (int e = 0; e < OUT_DIM; e++) begin
            if (r_idx == c_idx_w'(e)) begin
                w_sum = r_mem[r_rd_ptr][e];
            end
        end
    end

`ifdef RELU_EN
    assign w_act = w_sum[DATA_W-1] ? '0 : w_sum;
`else
    assign w_act = w_sum;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_act;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_last;
    assign bus.occupancy = r_occ;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_result_drain
//  Description : Directed self-checking bench for systolic_result_drain
//                (DATA_W=32, OUT_DIM=3, FIFO_DEPTH=4). Expected values are
//                pre-activation sums; act() applies ReLU when RELU_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;
    localparam int DATA_W     = 32;
    localparam int OUT_DIM    = 3;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    systolic_result_drain_if #(
        .DATA_W     (DATA_W),
        .OUT_DIM    (OUT_DIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

    systolic_result_drain #(
        .DATA_W     (DATA_W),
        .OUT_DIM    (OUT_DIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] act(input logic [31:0] s);
`ifdef RELU_EN
        return s[31] ? 32'h0 : s;
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks the element presented at the current sample point.
    task automatic check_beat(input string tag, input logic [31:0] sum,
                              input int idx, input logic last);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".data"},  bus.out_data, act(sum));
        check({tag, ".idx"},   32'(bus.out_idx), 32'(idx));
        check({tag, ".last"},  32'(bus.out_last), 32'(last));
    endtask

    // Drives one res_valid pulse over the next posedge.
    task automatic pulse(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        bus.res_valid  = 1'b1;
        bus.res_vec[0] = v0; bus.res_vec[1] = v1; bus.res_vec[2] = v2;
        bus.bias[0]    = b0; bus.bias[1]    = b1; bus.bias[2]    = b2;
        step();
        bus.res_valid  = 1'b0;
    endtask

    // Vector k of the fill tests: elements 16k+e, bias k, so sums are 17k+e.
    task automatic pulse_k(input int k);
        pulse(32'(16*k), 32'(16*k+1), 32'(16*k+2), 32'(k), 32'(k), 32'(k));
    endtask

    task automatic drain_k(input string tag, input int k);
        for (int e = 0; e < OUT_DIM; e++) begin
            check_beat(tag, 32'(17*k+e), e, e == OUT_DIM-1);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_vec   = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b1;

        // Reset held for two cycles.
        step(); step();
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.occ",   32'(bus.occupancy), 32'd0);
        check("rst.ovf",   32'(bus.overflow),  32'd0);
        reset = 1'b1;
        step();
        check("idle.valid", 32'(bus.out_valid), 32'd0);

        // Basic vector {5,-2,7} + {1,1,1}; valid one cycle after the pulse.
        pulse(32'd5, 32'hFFFF_FFFE, 32'd7, 32'd1, 32'd1, 32'd1);
        check("basic.occ", 32'(bus.occupancy), 32'd1);
        check_beat("basic0", 32'd6, 0, 1'b0);
        step();
        check_beat("basic1", 32'hFFFF_FFFF, 1, 1'b0);
        step();
        check_beat("basic2", 32'd8, 2, 1'b1);
        step();
        check("basic.done", 32'(bus.out_valid), 32'd0);
        check("basic.occ0", 32'(bus.occupancy), 32'd0);

        // Two's complement wrap of the bias add.
        pulse(32'h7FFF_FFFF, 32'd0, 32'd3, 32'd1, 32'd0, 32'hFFFF_FFFC);
        check_beat("wrap0", 32'h8000_0000, 0, 1'b0);
        step();
        check_beat("wrap1", 32'd0, 1, 1'b0);
        step();
        check_beat("wrap2", 32'hFFFF_FFFF, 2, 1'b1);
        step();
        check("wrap.done", 32'(bus.out_valid), 32'd0);

        // Back-pressure: five pulses into a four-deep FIFO.
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) pulse_k(k);
        check("ovf.occ",  32'(bus.occupancy), 32'd4);
        check("ovf.flag", 32'(bus.overflow),  32'd1);
        check_beat("hold0", 32'd17, 0, 1'b0);
        step();
        check_beat("hold1", 32'd17, 0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check_beat("hold2", 32'd18, 1, 1'b0);
        step();
        check_beat("hold3", 32'd19, 2, 1'b1);
        step();
        for (int k = 2; k <= 4; k++) drain_k("ovfdrain", k);
        check("ovf.absent", 32'(bus.out_valid), 32'd0);
        check("ovf.occ0",   32'(bus.occupancy), 32'd0);
        check("ovf.sticky", 32'(bus.overflow),  32'd1);

        // Full FIFO with a pulse on the last-element handshake.
        reset = 1'b0;
        step();
        check("rst2.ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) pulse_k(k);
        check("full.occ", 32'(bus.occupancy), 32'd4);
        check("full.ovf", 32'(bus.overflow),  32'd0);
        bus.out_ready = 1'b1;
        check_beat("full0", 32'd17, 0, 1'b0);
        step();
        check_beat("full1", 32'd18, 1, 1'b0);
        step();
        check_beat("full2", 32'd19, 2, 1'b1);
        pulse_k(9);
        check("same.occ", 32'(bus.occupancy), 32'd4);
        check("same.ovf", 32'(bus.overflow),  32'd0);
        for (int k = 2; k <= 4; k++) drain_k("samedrain", k);
        drain_k("samenew", 9);
        check("same.done", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a vector.
        pulse_k(6);
        check_beat("mid0", 32'd102, 0, 1'b0);
        step();
        check_beat("mid1", 32'd103, 1, 1'b0);
        reset = 1'b0;
        step();
        check("mid.valid", 32'(bus.out_valid), 32'd0);
        check("mid.occ",   32'(bus.occupancy), 32'd0);
        reset = 1'b1;
        step();
        pulse_k(7);
        drain_k("restart", 7);
        check("restart.done", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
